// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional trailing-checksum feature is enabled by defining IMEM_CHECKSUM_EN.
package imem_boot_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    // States in which the loader is willing to take a byte from the source.
    function automatic logic rx_state(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_if.sv
// Byte-stream, instruction-memory and core-control signals of the boot loader.
// Byte handshake: a byte transfers on a rising edge where rx_valid & rx_ready are both 1;
// rx_data must be held while rx_valid=1 and rx_ready=0, and is never consumed in that case.
interface imem_boot_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] pc_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        core_rst;
    logic        load_done;
    logic        err;

    modport master (
        output rx_data, rx_valid, pc_addr,
        input  rx_ready, mem_addr, mem_wdata, mem_we, core_rst, load_done, err
    );

    modport slave (
        input  rx_data, rx_valid, pc_addr,
        output rx_ready, mem_addr, mem_wdata, mem_we, core_rst, load_done, err
    );

endinterface

// File: rtl/imem_boot_ctrl_packer.sv
// Packs consecutive bytes into a little-endian 32-bit word; the first byte lands in bits [7:0].
module imem_byte_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_valid) begin
            r_word <= {i_byte, r_word[31:8]};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // The completed word is presented in the cycle its last byte arrives.
    assign o_word       = {i_byte, r_word[31:8]};
    assign o_word_valid = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: receives a length-prefixed image, writes it to instruction memory, then releases the core.
// Define IMEM_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
)
(
    input  logic        clk,
    input  logic        rst,
    imem_boot_if.slave  bus,
    output state_t      o_state
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    state_t           r_state;
    state_t           w_next;
    logic             r_rx_ready;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_word_idx;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_mem_we;
    logic             r_core_rst;
    logic             r_load_done;
    logic             r_err;

    logic             w_accept;
    logic             w_word_valid;
    logic [31:0]      w_word;
    logic             w_in_range;
    logic             w_ovf;
    logic             w_last;
    logic [LEN_W-1:0] w_len_full;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    assign w_accept   = bus.rx_valid & r_rx_ready;
    assign w_len_full = {bus.rx_data, r_len[7:0]};
    assign w_in_range = {{(32-LEN_W){1'b0}}, r_word_idx} < DEPTH_U;
    assign w_ovf      = {{(32-LEN_W){1'b0}}, r_len} > DEPTH_U;
    assign w_last     = (r_word_idx == r_len - 1'b1);

    imem_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (w_accept && (r_state == ST_DATA)),
        .i_byte       (bus.rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LEN0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LEN0: begin
                if (w_accept) w_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_accept) begin
`ifdef IMEM_CHECKSUM_EN
                    w_next = (w_len_full == '0) ? ST_CSUM : ST_DATA;
`else
                    w_next = (w_len_full == '0) ? ST_RUN : ST_DATA;
`endif
                end
            end
            ST_DATA: begin
                if (w_word_valid) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (w_last) begin
`ifdef IMEM_CHECKSUM_EN
                    w_next = ST_CSUM;
`else
                    w_next = w_ovf ? ST_HALT : ST_RUN;
`endif
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_CSUM: begin
`ifdef IMEM_CHECKSUM_EN
                // Overflow wins even when the checksum matches.
                if (w_accept) w_next = (bus.rx_data == r_csum && !w_ovf) ? ST_RUN : ST_HALT;
`else
                w_next = ST_HALT;
`endif
            end
            ST_RUN:  w_next = ST_RUN;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_HALT;
        endcase
    end

    // Outputs are registered from the next state so they change together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_ready  <= 1'b0;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_we    <= 1'b0;
            r_core_rst  <= 1'b0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rx_ready  <= rx_state(w_next);
            r_mem_we    <= 1'b0;
            r_core_rst  <= (w_next == ST_RUN);
            r_load_done <= (w_next == ST_RUN);
            r_err       <= (w_next == ST_HALT);
            if (r_state == ST_LEN0 && w_accept) r_len[7:0] <= bus.rx_data;
            if (r_state == ST_LEN1 && w_accept) r_len[LEN_W-1:8] <= bus.rx_data;
            if (w_word_valid) begin
                r_mem_we    <= w_in_range;
                r_mem_addr  <= {{(30-LEN_W){1'b0}}, r_word_idx, 2'b00};
                r_mem_wdata <= w_word;
            end
            if (r_state == ST_WRITE) r_word_idx <= r_word_idx + 1'b1;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= 8'd0;
        end else if (r_state == ST_DATA && w_accept) begin
            r_csum <= r_csum ^ bus.rx_data;
        end
    end
`endif

    // Once running, the core's fetch PC drives the memory address with no register in between.
    assign bus.mem_addr  = (r_state == ST_RUN) ? bus.pc_addr : r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.rx_ready  = r_rx_ready;
    assign bus.core_rst  = r_core_rst;
    assign bus.load_done = r_load_done;
    assign bus.err       = r_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard; memory depth shrunk to 4 words.
module tb_imem_boot_ctrl;
    import imem_boot_pkg::*;

    localparam int DEPTH = 4;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    imem_boot_if bus();

    imem_boot_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    logic [63:0] exp_q[$];
    logic [7:0]  img_q[$];
    logic [31:0] word_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.mem_we === 1'b1) begin
            n_writes++;
            check("rx_ready_in_write", 64'(bus.rx_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
            check("rst_core_rst", 64'(bus.core_rst), 64'd0);
            check("rst_mem_we",   64'(bus.mem_we),   64'd0);
        end
        check("rst_load_done", 64'(bus.load_done), 64'd0);
        check("rst_err",       64'(bus.err),       64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_state",     64'(dbg_state),     64'(ST_LEN0));
        bus.rx_valid = 1'b0;
        rst          = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rx_ready_after_rst", 64'(bus.rx_ready), 64'd1);
    endtask

    // Build img_q from word_q and queue the writes that must reach memory.
    task automatic make_image();
        logic [7:0] cs;
        int n;
        n  = word_q.size();
        cs = 8'h00;
        img_q.delete();
        img_q.push_back(8'(n));
        img_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                img_q.push_back(word_q[i][8*b +: 8]);
                cs = cs ^ word_q[i][8*b +: 8];
            end
            if (i < DEPTH) exp_q.push_back({32'(i * 4), word_q[i]});
        end
`ifdef IMEM_CHECKSUM_EN
        img_q.push_back(cs);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit bursty);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        if (bursty) @(negedge clk);
    endtask

    task automatic send_image(input bit bursty);
        for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i], bursty);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(bus.load_done === 1'b1 || bus.err === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("end_timeout", 64'(n < 20), 64'd1);
    endtask

    task automatic check_run(input string tag);
        logic [31:0] pc;
        check({tag, "_core_rst"},  64'(bus.core_rst),  64'd1);
        check({tag, "_load_done"}, 64'(bus.load_done), 64'd1);
        check({tag, "_err"},       64'(bus.err),       64'd0);
        check({tag, "_state"},     64'(dbg_state),     64'(ST_RUN));
        check({tag, "_rx_ready"},  64'(bus.rx_ready),  64'd0);
        check({tag, "_pending"},   64'(exp_q.size()),  64'd0);
        bus.pc_addr = 32'h8;
        #1;
        check({tag, "_pc_8"}, 64'(bus.mem_addr), 64'h8);
        pc = $urandom_range(32'h0, 32'hFFFF) & 32'hFFFC;
        bus.pc_addr = pc;
        #1;
        check({tag, "_pc_rand"}, 64'(bus.mem_addr), 64'(pc));
        bus.pc_addr = 32'h0;
    endtask

    initial begin
        int w0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.pc_addr  = 32'h0;

        // Two-word load, back-to-back bytes
        do_reset();
        word_q = '{32'h0062E233, 32'h00B62423};
        make_image();
        w0 = n_writes;
        send_image(1'b0);
        wait_end();
        check("two_word_writes", 64'(n_writes - w0), 64'd2);
        check_run("two_word");

        // Same image from a source that idles every other cycle
        do_reset();
        make_image();
        w0 = n_writes;
        send_image(1'b1);
        wait_end();
        check("bursty_writes", 64'(n_writes - w0), 64'd2);
        check_run("bursty");

        // Zero-length image
        do_reset();
        word_q.delete();
        make_image();
        w0 = n_writes;
        send_image(1'b0);
        wait_end();
        check("zero_len_writes", 64'(n_writes - w0), 64'd0);
        check_run("zero_len");

        // Overflow: one word more than the memory holds
        do_reset();
        word_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) word_q.push_back($urandom());
        make_image();
        w0 = n_writes;
        send_image(1'b0);
        wait_end();
        check("ovf_writes",    64'(n_writes - w0),  64'(DEPTH));
        check("ovf_err",       64'(bus.err),        64'd1);
        check("ovf_core_rst",  64'(bus.core_rst),   64'd0);
        check("ovf_load_done", 64'(bus.load_done),  64'd0);
        check("ovf_rx_ready",  64'(bus.rx_ready),   64'd0);
        check("ovf_state",     64'(dbg_state),      64'(ST_HALT));
        check("ovf_pending",   64'(exp_q.size()),   64'd0);

        // Reset after 5 payload bytes, then a fresh one-word image
        do_reset();
        word_q = '{32'hA1B2C3D4, 32'h11223344};
        make_image();
        exp_q.delete();
        exp_q.push_back({32'h0, 32'hA1B2C3D4});
        for (int i = 0; i < 7; i++) send_byte(img_q[i], 1'b0);
        @(negedge clk);
        check("midload_first_word", 64'(exp_q.size()), 64'd0);
        do_reset();
        word_q = '{32'h00000013};
        make_image();
        w0 = n_writes;
        send_image(1'b0);
        wait_end();
        check("reload_writes", 64'(n_writes - w0), 64'd1);
        check_run("reload");

`ifdef IMEM_CHECKSUM_EN
        // Corrupted checksum byte
        do_reset();
        word_q = '{32'h00000013};
        make_image();
        img_q[img_q.size() - 1] = img_q[img_q.size() - 1] ^ 8'h5A;
        send_image(1'b0);
        wait_end();
        check("bad_csum_err",      64'(bus.err),      64'd1);
        check("bad_csum_core_rst", 64'(bus.core_rst), 64'd0);
        check("bad_csum_state",    64'(dbg_state),    64'(ST_HALT));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-time controller for the pipelined RV32I core's instruction memory. It receives a length-prefixed program image as a byte stream, packs the bytes into little-endian 32-bit words, and writes them sequentially into instruction memory. Until loading is complete it holds the core in reset. Once loading completes it gives the memory address port to the core's fetch PC.

## Interface
Parameters:
- DEPTH_WORDS, 1024, instruction memory depth in words; writes at or beyond this index are suppressed.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx_data  in  8  image byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  controller accepts a byte; transfer occurs on a cycle where rx_valid & rx_ready.
- pc_addr  in  32  core fetch byte address.
- mem_addr  out  32  instruction memory byte address; memory indexes by bits [31:2].
- mem_wdata  out  32  word to write.
- mem_we  out  1  write strobe, one cycle per word.
- core_rst  out  1  active-low reset to the core; 0 holds the core.
- load_done  out  1  image loaded successfully; core released.
- err  out  1  sticky error.

## Operation
- Image format: 2 length bytes giving word count N (16-bit, LSB first), then 4·N payload bytes. Each word is sent LSB first.
- States:
  - LEN0: accept length LSB → LEN1.
  - LEN1: accept length MSB. If N==0 → RUN (or CSUM if configured); else → DATA.
  - DATA: accept bytes into the packer. On the 4th byte → WRITE.
  - WRITE: one cycle. mem_we=1 (suppressed if word_idx ≥ DEPTH_WORDS), mem_addr={word_idx[29:0],2'b00}, mem_wdata=packed word. Then word_idx++. If this was word N−1 → RUN (or CSUM if configured); else → DATA.
  - RUN: terminal. mem_addr=pc_addr, mem_we=0, core_rst=1, load_done=1.
  - HALT: terminal. core_rst=0, err=1, rx_ready=0, load_done=0.
- rx_ready=1 only in LEN0, LEN1 and DATA (plus CSUM when configured). It is 0 in WRITE, so there is no byte backpressure loss. Bytes offered while rx_ready=0 are not consumed.
- Overflow: if N > DEPTH_WORDS, words with index ≥ DEPTH_WORDS are consumed but not written. The end-of-image transition goes to HALT instead of RUN.
- While not in RUN, mem_addr is the loader address and pc_addr is ignored.
- Only reset exits RUN or HALT. Reset mid-load discards partial words and the counter. Restarts at LEN0 with word_idx=0.

## Timing
- Reset values (while rst=0): state LEN0, word_idx 0, rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_rst 0, load_done 0, err 0.
- rx_ready rises in the first cycle after rst deasserts.
- Best-case throughput: 1 byte/cycle. Each word costs 4 accept cycles plus 1 WRITE cycle.
- Outputs are registered.
  - core_rst and load_done rise in the first cycle in RUN.
  - mem_addr switches to pc_addr in that same cycle, combinationally from the PC.
- Write timing: mem_we is high for exactly the WRITE cycle, with address and data stable in that cycle.

## Configuration
- IMEM_CHECKSUM_EN defined:
  - One trailing checksum byte follows the payload, in state CSUM; with N==0 it directly follows the length.
  - The controller XORs all payload bytes. Match → RUN; mismatch → HALT with err=1.
  - Overflow still forces HALT regardless of checksum.
- IMEM_CHECKSUM_EN undefined:
  - No CSUM state and no checksum byte.
  - err is set only by overflow.

## Structure
- Package imem_boot_pkg holds:
  - the state enum (LEN0, LEN1, DATA, WRITE, CSUM, RUN, HALT);
  - the length field width (16);
  - bytes per word (4).
- Sub-module imem_byte_packer:
  - 2-bit byte counter plus 32-bit shift/assemble register;
  - outputs word_valid on the 4th byte;
  - cleared by reset.

## Test plan
- Reset hold:
  - Stimulus: rst=0 for 5 cycles with rx_valid=1.
  - Required: rx_ready=0, core_rst=0, mem_we=0, no bytes consumed.
- Two-word load:
  - Stimulus: bytes 02 00 33 E2 62 00 23 24 B6 00.
  - Required: writes 0x0062E233 @0x0 then 0x00B62423 @0x4, then RUN with core_rst=1, load_done=1, mem_addr following pc_addr=0x8.
- Bursty source:
  - Stimulus: same image with rx_valid toggling every other cycle.
  - Required: identical writes, no lost or duplicated bytes, rx_ready=0 during each WRITE.
- Zero length:
  - Stimulus: 00 00 (plus checksum 00 if configured).
  - Required: RUN with no mem_we pulse.
- Overflow:
  - Stimulus: DEPTH_WORDS=4, N=5.
  - Required: 4 writes; 5th consumed without mem_we; HALT with err=1, core_rst=0.
- Mid-load reset:
  - Stimulus: assert rst after 5 payload bytes, then reload a 1-word image 01 00 13 00 00 00.
  - Required: single write 0x00000013 @0x0, RUN.
  - With IMEM_CHECKSUM_EN, a wrong checksum byte → HALT with err=1.
